// File: rtl/kernel_ctrl_mc_pkg.sv
// Shared types and defaults for the multi-channel kernel launch controller.
package kernel_ctrl_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEFAULT_XFER_BYTES = 16384;
    localparam int MAX_NUM_CH         = 16;

endpackage

// File: rtl/kernel_ctrl_mc_done_tracker.sv
// Sticky per-channel completion tracking; reports when every enabled channel has finished.
module kernel_ctrl_mc_done_tracker #(
    parameter int NUM_CH = 4
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              clear,
    input  logic              track,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              all_done
);

    logic [NUM_CH-1:0] sticky;
    logic [NUM_CH-1:0] hit;

    // Pulses from disabled channels never reach the sticky vector.
    assign hit = ch_done & mask;

    always_ff @(posedge ap_clk) begin
        if (areset || clear) begin
            sticky <= '0;
        end else if (track) begin
            sticky <= sticky | hit;
        end
    end

    // Same-cycle pulse counts, so completion is seen without an extra cycle of latency.
    assign all_done = ((sticky | hit) == mask);

endmodule

// File: rtl/kernel_ctrl_mc.sv
// Multi-channel kernel launch controller (ap_ctrl_hs by default).
// Define KERNEL_CTRL_MC_CHAIN_EN for ap_ctrl_chain: DONE holds until ap_continue.
module kernel_ctrl_mc
    import kernel_ctrl_mc_pkg::*;
#(
    parameter int C_NUM_CH             = 4,
    parameter int C_XFER_SIZE_WIDTH    = 32,
    parameter int C_CNT_WIDTH          = 32,
    parameter int C_DEFAULT_XFER_BYTES = DEFAULT_XFER_BYTES
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_NUM_CH-1:0]          ctrl_ch_mask,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size,
    output logic [C_NUM_CH-1:0]          ch_start,
    input  logic [C_NUM_CH-1:0]          ch_done,
    output logic [C_CNT_WIDTH-1:0]       cycle_count
);

    localparam logic [C_XFER_SIZE_WIDTH-1:0] DEF_SIZE = C_XFER_SIZE_WIDTH'(C_DEFAULT_XFER_BYTES);

    state_t              state;
    state_t              state_nxt;
    logic [C_NUM_CH-1:0] mask_q;
    logic                accept;
    logic                active;
    logic                all_done;

    assign accept = (state == ST_IDLE) && ap_start;
    assign active = (state == ST_START) || (state == ST_RUN);

    kernel_ctrl_mc_done_tracker #(
        .NUM_CH (C_NUM_CH)
    ) u_done_tracker (
        .ap_clk   (ap_clk),
        .areset   (areset),
        .clear    (accept),
        .track    (active),
        .mask     (mask_q),
        .ch_done  (ch_done),
        .all_done (all_done)
    );

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            ch_start     <= '0;
            cycle_count  <= '0;
            ch_xfer_size <= DEF_SIZE;
        end else begin
            state    <= state_nxt;
            // Registered so the pulse lines up exactly with the START cycle.
            ch_start <= accept ? ctrl_ch_mask : '0;
            if (accept) begin
                mask_q       <= ctrl_ch_mask;
                ch_xfer_size <= (ctrl_xfer_size_in_bytes == '0) ? DEF_SIZE : ctrl_xfer_size_in_bytes;
                cycle_count  <= '0;
            end else if (active && (cycle_count != '1)) begin
                cycle_count <= cycle_count + C_CNT_WIDTH'(1);
            end
        end
    end

`ifdef KERNEL_CTRL_MC_CHAIN_EN
    logic done_first;

    // High only in the first DONE cycle, since DONE is always entered from RUN.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            done_first <= 1'b0;
        end else begin
            done_first <= (state != ST_DONE);
        end
    end

    assign ap_ready = (state == ST_DONE) && done_first;
`else
    logic continue_unused;

    assign continue_unused = ap_continue;
    assign ap_ready        = (state == ST_DONE);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ap_start) state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN:   if (all_done) state_nxt = ST_DONE;
`ifdef KERNEL_CTRL_MC_CHAIN_EN
            ST_DONE:  if (ap_continue) state_nxt = ST_IDLE;
`else
            ST_DONE:  state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign ap_idle = (state == ST_IDLE);
    assign ap_done = (state == ST_DONE);

endmodule

// File: tb/tb_kernel_ctrl_mc.sv
// Self-checking bench for kernel_ctrl_mc: directed scenarios plus randomized runs vs a run-level model.
module tb_kernel_ctrl_mc;

`ifdef KERNEL_CTRL_MC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif
    localparam int DEF_BYTES = 16384;
    localparam int SAT_W     = 4;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_continue = 1'b1;
    logic [3:0]  ctrl_ch_mask = '0;
    logic [31:0] ctrl_xfer_size_in_bytes = '0;
    logic [3:0]  ch_done = '0;

    logic        ap_idle, ap_done, ap_ready;
    logic [31:0] ch_xfer_size;
    logic [3:0]  ch_start;
    logic [31:0] cycle_count;

    logic        s_ap_idle, s_ap_done, s_ap_ready;
    logic [31:0] s_ch_xfer_size;
    logic [3:0]  s_ch_start;
    logic [3:0]  s_cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    kernel_ctrl_mc dut (
        .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .ctrl_ch_mask(ctrl_ch_mask), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .ch_xfer_size(ch_xfer_size), .ch_start(ch_start), .ch_done(ch_done),
        .cycle_count(cycle_count)
    );

    kernel_ctrl_mc #(.C_CNT_WIDTH(SAT_W)) dut_sat (
        .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(s_ap_idle), .ap_done(s_ap_done), .ap_ready(s_ap_ready),
        .ctrl_ch_mask(ctrl_ch_mask), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .ch_xfer_size(s_ch_xfer_size), .ch_start(s_ch_start), .ch_done(ch_done),
        .cycle_count(s_cycle_count)
    );

    function automatic int sat(input int v);
        return (v > (1 << SAT_W) - 1) ? (1 << SAT_W) - 1 : v;
    endfunction

    // One whole run, starting and ending at a falling edge with the DUT idle.
    // d[i]: cycle of the first done pulse on channel i (0 = START cycle, 1.. = RUN cycles).
    task automatic do_run(input logic [3:0] mask, input logic [31:0] size, input int d[4],
                          input bit noise, input int hold, input bit keep_start);
        int r, done_len, exp_size;
        logic [3:0] v;
        r = 1;
        for (int i = 0; i < 4; i++) if (mask[i] && d[i] > r) r = d[i];
        done_len = CHAIN ? hold + 1 : 1;
        exp_size = (size == 0) ? DEF_BYTES : int'(size);

        n_cmp++; if (ap_idle !== 1'b1) begin n_bad++; $display("FAIL pre_idle: got %b want 1", ap_idle); end
        ap_start = 1'b1; ctrl_ch_mask = mask; ctrl_xfer_size_in_bytes = size; ap_continue = 1'b1;
        ch_done = noise ? 4'($urandom) : 4'b0;

        for (int t = 0; t <= r; t++) begin
            @(negedge ap_clk);
            if (!keep_start) ap_start = 1'b0;
            n_cmp++; if (ap_idle !== 1'b0) begin n_bad++; $display("FAIL run_idle t=%0d: got %b want 0", t, ap_idle); end
            n_cmp++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin n_bad++; $display("FAIL early_done t=%0d: got done=%b ready=%b want 0", t, ap_done, ap_ready); end
            n_cmp++; if (ch_start !== ((t == 0) ? mask : 4'b0)) begin n_bad++; $display("FAIL ch_start t=%0d: got %b want %b", t, ch_start, (t == 0) ? mask : 4'b0); end
            n_cmp++; if (cycle_count !== 32'(t)) begin n_bad++; $display("FAIL run_count t=%0d: got %0d want %0d", t, cycle_count, t); end
            n_cmp++; if (s_cycle_count !== 4'(sat(t))) begin n_bad++; $display("FAIL sat_run_count t=%0d: got %0d want %0d", t, s_cycle_count, sat(t)); end
            if (t == 0) begin
                n_cmp++; if (ch_xfer_size !== 32'(exp_size)) begin n_bad++; $display("FAIL xfer_size: got %0d want %0d", ch_xfer_size, exp_size); end
            end
            v = '0;
            for (int i = 0; i < 4; i++)
                if (mask[i]) v[i] = (t == d[i]) || (noise && t > d[i] && $urandom_range(3) == 0);
                else         v[i] = noise && ($urandom_range(1) == 1);
            ch_done = v;
            if (noise) begin ctrl_ch_mask = 4'($urandom); ctrl_xfer_size_in_bytes = $urandom; end
        end

        for (int k = 0; k < done_len; k++) begin
            @(negedge ap_clk);
            n_cmp++; if (ap_done !== 1'b1 || s_ap_done !== 1'b1) begin n_bad++; $display("FAIL ap_done k=%0d: got %b/%b want 1", k, ap_done, s_ap_done); end
            n_cmp++; if (ap_ready !== (k == 0)) begin n_bad++; $display("FAIL ap_ready k=%0d: got %b want %b", k, ap_ready, k == 0); end
            n_cmp++; if (ap_idle !== 1'b0 || ch_start !== 4'b0) begin n_bad++; $display("FAIL done_state k=%0d: got idle=%b ch_start=%b want 0/0", k, ap_idle, ch_start); end
            n_cmp++; if (cycle_count !== 32'(r + 1)) begin n_bad++; $display("FAIL done_count: got %0d want %0d", cycle_count, r + 1); end
            n_cmp++; if (s_cycle_count !== 4'(sat(r + 1))) begin n_bad++; $display("FAIL sat_done_count: got %0d want %0d", s_cycle_count, sat(r + 1)); end
            ap_continue = (k >= hold);
            ch_done = noise ? 4'($urandom) : 4'b0;
        end

        @(negedge ap_clk);
        n_cmp++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin n_bad++; $display("FAIL post_idle: got idle=%b done=%b ready=%b want 1/0/0", ap_idle, ap_done, ap_ready); end
        n_cmp++; if (cycle_count !== 32'(r + 1)) begin n_bad++; $display("FAIL idle_count: got %0d want %0d", cycle_count, r + 1); end
        n_cmp++; if (s_cycle_count !== 4'(sat(r + 1))) begin n_bad++; $display("FAIL sat_idle_count: got %0d want %0d", s_cycle_count, sat(r + 1)); end
        n_cmp++; if (ch_xfer_size !== 32'(exp_size)) begin n_bad++; $display("FAIL size_hold: got %0d want %0d", ch_xfer_size, exp_size); end
        ap_start = keep_start; ap_continue = 1'b1; ch_done = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        for (int ph = 0; ph < 2; ph++) begin
            n_cmp++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl ph=%0d: got idle=%b done=%b ready=%b want 1/0/0", ph, ap_idle, ap_done, ap_ready); end
            n_cmp++; if (ch_start !== 4'b0 || cycle_count !== 32'd0 || s_cycle_count !== 4'd0) begin n_bad++; $display("FAIL reset_regs ph=%0d: got ch_start=%b count=%0d want 0/0", ph, ch_start, cycle_count); end
            n_cmp++; if (ch_xfer_size !== 32'(DEF_BYTES)) begin n_bad++; $display("FAIL reset_size ph=%0d: got %0d want %0d", ph, ch_xfer_size, DEF_BYTES); end
            areset = 1'b0;
            @(negedge ap_clk);
        end
    endtask

    // Spec example: dones at RUN cycles 3,7,7,12 counted from 0 -> offsets 4,8,8,13 here.
    task automatic test_spec_example();
        int d[4] = '{4, 8, 8, 13};
        do_run(4'b1111, 32'd0, d, 1'b0, 0, 1'b0);
    endtask

    task automatic test_partial_mask();
        int d[4] = '{6, 0, 6, 0};
        do_run(4'b0101, 32'd4096, d, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero_mask();
        int d[4] = '{0, 0, 0, 0};
        do_run(4'b0000, 32'd77, d, 1'b1, 0, 1'b0);
    endtask

    task automatic test_continue();
        int d[4] = '{2, 0, 0, 0};
        do_run(4'b0001, 32'd512, d, 1'b0, 5, 1'b0);
        do_run(4'b0011, 32'd0, '{3, 1, 0, 0}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        ap_start = 1'b1; ctrl_ch_mask = 4'b0001; ctrl_xfer_size_in_bytes = 32'd100;
        @(negedge ap_clk); ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        ch_done = 4'b0001; areset = 1'b1;
        @(negedge ap_clk);
        areset = 1'b0; ch_done = '0;
        n_cmp++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin n_bad++; $display("FAIL abort_state: got idle=%b done=%b want 1/0", ap_idle, ap_done); end
        n_cmp++; if (cycle_count !== 32'd0 || s_cycle_count !== 4'd0) begin n_bad++; $display("FAIL abort_count: got %0d want 0", cycle_count); end
        n_cmp++; if (ch_xfer_size !== 32'(DEF_BYTES)) begin n_bad++; $display("FAIL abort_size: got %0d want %0d", ch_xfer_size, DEF_BYTES); end
        for (int k = 0; k < 6; k++) begin
            ch_done = 4'($urandom);
            @(negedge ap_clk);
            n_cmp++; if (ap_done !== 1'b0 || ap_idle !== 1'b1 || cycle_count !== 32'd0) begin n_bad++; $display("FAIL post_abort k=%0d: got done=%b idle=%b count=%0d want 0/1/0", k, ap_done, ap_idle, cycle_count); end
        end
        ch_done = '0;
    endtask

    task automatic test_saturation();
        int d[4] = '{19, 0, 0, 0};
        do_run(4'b0001, 32'd64, d, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            n_cmp++; if (s_cycle_count !== 4'd15 || cycle_count !== 32'd20) begin n_bad++; $display("FAIL sat_hold k=%0d: got %0d/%0d want 15/20", k, s_cycle_count, cycle_count); end
        end
    endtask

    task automatic test_back_to_back();
        do_run(4'b0010, 32'd8, '{0, 2, 0, 0}, 1'b0, 0, 1'b1);
        do_run(4'b1000, 32'd0, '{0, 0, 0, 0}, 1'b0, 0, 1'b1);
        do_run(4'b0110, 32'd9, '{0, 3, 5, 0}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        int d[4];
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(24);
            do_run(4'($urandom), ($urandom_range(2) == 0) ? 32'd0 : $urandom, d, 1'b1,
                   $urandom_range(3), $urandom_range(3) == 0);
        end
        if (ap_start) begin
            ap_start = 1'b0;
            repeat (4) @(negedge ap_clk);
        end
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_partial_mask();
        test_zero_mask();
        test_continue();
        test_reset_mid_run();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
